decode_stage_rv32: RTL and testbench
====================================

// Module: decode_stage_rv32
// PURPOSE
//  Registered RV32I decode stage; successor to the combinational I-type decoder.
//  Decodes I/S/B/U/J formats to register indices, sign-extended XLEN immediate,
//  ALU control and format tag, behind valid/ready handshakes. Sits between fetch and execute.
//  Flags illegal encodings and keeps a saturating illegal-instruction counter.
// PARAMETERS
//  XLEN        32  immediate output width; imm sign-extended from bit 31 of the instruction
//  ALU_CTRL_W  5   ALU control width; encodings below use the low 4 bits, upper bits 0
//  CNT_W       16  width of illegal-instruction counter
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           asynchronous reset, active low
//  flush        in   1           synchronous pipeline flush
//  in_valid     in   1           in_instr valid
//  in_ready     out  1           stage can accept
//  in_instr     in   32          raw instruction word
//  out_valid    out  1           decoded fields valid
//  out_ready    in   1           execute stage accepts
//  rs1,rs2,rd   out  5 each      register indices; 0 when unused by format
//  imm          out  XLEN        sign-extended immediate; 0 for R-type
//  alu_control  out  ALU_CTRL_W  ALU operation
//  fmt          out  3           0=R 1=I 2=S 3=B 4=U 5=J
//  illegal      out  1           unsupported opcode/funct
//  ill_cnt      out  CNT_W       illegal instructions accepted, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, all data outputs 0, ill_cnt=0; in_ready=1 after reset deasserts.
//  - Transfer on valid&ready each side. Latency 1 cycle in->out; throughput 1/cycle.
//  - in_ready = !out_valid | out_ready (base build). Accept updates all outputs same edge.
//  - Outputs stable while out_valid & !out_ready. Load with no accept: out_valid<=0 on drain.
//  - ALU encodings: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10.
//  - OP(0110011): R; funct3/funct7[5] select op; funct7 other than 0x00/0x20 -> illegal.
//  - OP-IMM(0010011): I; shifts give imm=zero-extended shamt, funct7[5] selects SRL/SRA.
//  - LOAD(0000011), JALR(1100111): I, ADD. STORE(0100011): S, ADD.
//  - BRANCH(1100011): B, BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU; funct3 010/011 illegal.
//  - LUI(0110111): U, PASSB, imm={instr[31:12],12'b0}. AUIPC(0010111): U, ADD. JAL(1101111): J, ADD.
//  - Any other opcode, or instr[1:0]!=2'b11: illegal=1, alu=ADD, fmt=I, fields 0.
//  - ill_cnt increments on each accepted illegal word; holds at all-ones.
//  - flush: out_valid<=0 next edge; in-flight word dropped; flush wins over simultaneous accept;
//    ill_cnt unchanged by flush (word accepted in the flush cycle is not counted).
//  - rst_n low mid-transfer: immediate return to reset state; no partial output.
// CONFIGURATION
//  DECODE_SKID_BUF_EN defined: 2-entry skid buffer; in_ready registered (=!skid_full),
//   no combinational out_ready->in_ready path; latency 1, throughput 1/cycle; flush
//   clears both entries; order preserved.
//  Undefined: single output register, in_ready combinational as above.
// TESTING
//  - 0xFFF10093 (addi x1,x2,-1) -> rs1=2 rd=1 imm=0xFFFFFFFF alu=ADD fmt=I illegal=0, 1 cycle later.
//  - 0x40525193 (srai x3,x4,5) -> rs1=4 rd=3 imm=5 alu=SRA fmt=I.
//  - 0x00532423 (sw x5,8(x6)) -> rs1=6 rs2=5 rd=0 imm=8 fmt=S; 0x123453B7 (lui x7) -> imm=0x12345000 alu=PASSB.
//  - 0x00000000 x3 -> illegal=1 each, ill_cnt=3; CNT_W=2 bench with 5 illegal -> ill_cnt=3.
//  - out_ready=0 for 3 cycles with word held -> outputs stable, in_ready=0 (base) and no loss; burst of 8 -> order kept.
//  - flush with out_valid=1 -> out_valid=0 next cycle; rst_n pulse mid-burst -> all outputs 0, ill_cnt=0.

Source files
------------

// File: rtl/decode_stage_rv32.sv
// decode_stage_rv32: registered RV32I decoder with valid/ready handshakes and saturating illegal counter.
// Define DECODE_SKID_BUF_EN for a 2-entry skid buffer with registered in_ready.
module decode_stage_rv32 #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       imm,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            fmt,
  output logic                  illegal,
  output logic [CNT_W-1:0]      ill_cnt
);
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                         A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9,
                         A_PASSB = 4'd10;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_JALR = 7'h67,
                         OP_STORE = 7'h23, OP_BR = 7'h63, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                         OP_JAL = 7'h6f;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic [2:0]      fmt;
    logic            ill;
  } dec_t;

  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [3:0]  alu_f3;
  logic [31:0] imm32;
  dec_t        d, q;
  logic        acc;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // funct3 -> ALU op shared by OP and OP-IMM; instr[30] only picks SUB for register ops
  always_comb
    case (f3)
      3'b000:  alu_f3 = (op == OP_R && in_instr[30]) ? A_SUB : A_ADD;
      3'b001:  alu_f3 = A_SLL;
      3'b010:  alu_f3 = A_SLT;
      3'b011:  alu_f3 = A_SLTU;
      3'b100:  alu_f3 = A_XOR;
      3'b101:  alu_f3 = in_instr[30] ? A_SRA : A_SRL;
      3'b110:  alu_f3 = A_OR;
      default: alu_f3 = A_AND;
    endcase

  always_comb begin
    d = '0;
    d.fmt = F_I;
    imm32 = '0;
    case (op)
      OP_R: begin
        d.fmt = F_R;
        d.rs1 = in_instr[19:15];
        d.rs2 = in_instr[24:20];
        d.rd  = in_instr[11:7];
        d.alu = alu_f3;
        d.ill = f7 != 7'h00 && f7 != 7'h20;
      end
      OP_IMM: begin
        d.rs1 = in_instr[19:15];
        d.rd  = in_instr[11:7];
        d.alu = alu_f3;
        imm32 = (f3[1:0] == 2'b01) ? {27'b0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_LOAD, OP_JALR: begin
        d.rs1 = in_instr[19:15];
        d.rd  = in_instr[11:7];
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        d.fmt = F_S;
        d.rs1 = in_instr[19:15];
        d.rs2 = in_instr[24:20];
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BR: begin
        d.fmt = F_B;
        d.rs1 = in_instr[19:15];
        d.rs2 = in_instr[24:20];
        d.alu = f3[2] ? (f3[1] ? A_SLTU : A_SLT) : A_SUB;
        d.ill = f3[2:1] == 2'b01;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        d.fmt = F_U;
        d.rd  = in_instr[11:7];
        d.alu = (op == OP_LUI) ? A_PASSB : A_ADD;
        imm32 = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        d.fmt = F_J;
        d.rd  = in_instr[11:7];
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: d.ill = 1'b1;
    endcase
    d.imm = XLEN'($signed(imm32));
    if (d.ill) begin
      d = '0;
      d.fmt = F_I;
      d.ill = 1'b1;
    end
  end

  assign acc = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      ill_cnt <= '0;
    else if (acc && d.ill && !flush && !(&ill_cnt))
      ill_cnt <= ill_cnt + 1'b1;

`ifdef DECODE_SKID_BUF_EN
  dec_t q1;
  logic v1;
  // in_ready comes straight from the second-entry flop, so out_ready never reaches it combinationally
  assign in_ready = !v1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      v1        <= 1'b0;
      q         <= '0;
      q1        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      v1        <= 1'b0;
    end else if (out_valid && out_ready && v1) begin
      q  <= q1;
      v1 <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= acc;
      if (acc) q <= d;
    end else if (acc) begin
      q1 <= d;
      v1 <= 1'b1;
    end
`else
  assign in_ready = !out_valid | out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush)
      out_valid <= 1'b0;
    else if (acc) begin
      out_valid <= 1'b1;
      q         <= d;
    end else if (out_ready)
      out_valid <= 1'b0;
`endif

  assign rs1         = q.rs1;
  assign rs2         = q.rs2;
  assign rd          = q.rd;
  assign imm         = q.imm;
  assign alu_control = ALU_CTRL_W'(q.alu);
  assign fmt         = q.fmt;
  assign illegal     = q.ill;
endmodule

// File: tb/tb_decode_stage_rv32.sv
// tb_decode_stage_rv32: directed and randomized checks of decode_stage_rv32 against an arithmetic reference model.
module tb_decode_stage_rv32;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic        in_ready, out_valid, illegal;
  logic [4:0]  rs1, rs2, rd, alu_control;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [15:0] ill_cnt;

  logic        flush2 = 0, in_valid2 = 0, out_ready2 = 1;
  logic [31:0] in_instr2 = 0;
  logic        in_ready2, out_valid2, illegal2;
  logic [4:0]  rs1_2, rs2_2, rd_2, alu_control2;
  logic [31:0] imm2;
  logic [2:0]  fmt2;
  logic [1:0]  ill_cnt2;

  decode_stage_rv32 dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .alu_control(alu_control), .fmt(fmt), .illegal(illegal), .ill_cnt(ill_cnt)
  );

  decode_stage_rv32 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_instr(in_instr2), .out_valid(out_valid2), .out_ready(out_ready2), .rs1(rs1_2), .rs2(rs2_2),
    .rd(rd_2), .imm(imm2), .alu_control(alu_control2), .fmt(fmt2), .illegal(illegal2), .ill_cnt(ill_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [2:0]  fmt;
    logic        ill;
  } dec_t;

  int   n_vec = 0, n_bad = 0;
  dec_t sb[$];

  localparam int ND = 11;
  logic [31:0] dir_w[ND] = '{32'hFFF10093, 32'h40525193, 32'h00532423, 32'h123453B7, 32'h003100B3,
                             32'h403100B3, 32'h00208463, 32'hFFFFF0EF, 32'h00000000, 32'h00002063,
                             32'h02000033};
  dec_t dir_e[ND] = '{
    '{5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 5'd0,  3'd1, 1'b0},
    '{5'd4, 5'd0, 5'd3, 32'd5,        5'd7,  3'd1, 1'b0},
    '{5'd6, 5'd5, 5'd0, 32'd8,        5'd0,  3'd2, 1'b0},
    '{5'd0, 5'd0, 5'd7, 32'h12345000, 5'd10, 3'd4, 1'b0},
    '{5'd2, 5'd3, 5'd1, 32'd0,        5'd0,  3'd0, 1'b0},
    '{5'd2, 5'd3, 5'd1, 32'd0,        5'd1,  3'd0, 1'b0},
    '{5'd1, 5'd2, 5'd0, 32'd8,        5'd1,  3'd3, 1'b0},
    '{5'd0, 5'd0, 5'd1, 32'hFFFFFFFE, 5'd0,  3'd5, 1'b0},
    '{5'd0, 5'd0, 5'd0, 32'd0,        5'd0,  3'd1, 1'b1},
    '{5'd0, 5'd0, 5'd0, 32'd0,        5'd0,  3'd1, 1'b1},
    '{5'd0, 5'd0, 5'd0, 32'd0,        5'd0,  3'd1, 1'b1}
  };

  function automatic dec_t obs();
    return '{rs1, rs2, rd, imm, alu_control, fmt, illegal};
  endfunction

  // Reference decode: immediates rebuilt with signed integer arithmetic from the field weights
  function automatic dec_t model(input logic [31:0] w);
    dec_t e;
    int   s, r_alu[8];
    logic [2:0] f3;
    logic [6:0] f7;
    r_alu = '{0, 2, 3, 4, 5, 6, 8, 9};
    s  = w;
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.fmt = 1;
    case (w[6:0])
      7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin
        e.fmt = 0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.alu = 5'(r_alu[f3] + int'((f3 == 0 || f3 == 5) && f7[5]));
      end else e.ill = 1;
      7'h13: begin
        e.rs1 = w[19:15]; e.rd = w[11:7];
        e.alu = 5'(r_alu[f3] + int'(f3 == 5 && w[30]));
        e.imm = (f3 == 1 || f3 == 5) ? 32'(int'(w[24:20])) : 32'(s >>> 20);
      end
      7'h03, 7'h67: begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(s >>> 20); end
      7'h23: begin
        e.fmt = 2; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
      end
      7'h63: if (f3 == 2 || f3 == 3) e.ill = 1;
      else begin
        e.fmt = 3; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.alu = (f3 < 2) ? 5'd1 : (f3 < 6) ? 5'd3 : 5'd4;
        e.imm = 32'((s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      end
      7'h37, 7'h17: begin
        e.fmt = 4; e.rd = w[11:7]; e.alu = (w[6:0] == 7'h37) ? 5'd10 : 5'd0;
        e.imm = w & 32'hFFFFF000;
      end
      7'h6F: begin
        e.fmt = 5; e.rd = w[11:7];
        e.imm = 32'((s >>> 31) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e = '0; e.fmt = 1; e.ill = 1; end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[9];
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = ops[k];
    else if (k == 9) w[1:0] = 2'($urandom_range(0, 2));
    else if (k == 10) w = 0;
    if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 0;
    in_valid = 0; flush = 0; in_valid2 = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 0 || obs() !== '0 || ill_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset_state: out_valid=%b fields=%h ill_cnt=%0d, expected 0/0/0", out_valid, obs(), ill_cnt);
    end
    rst_n = 1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1) begin n_bad++; $display("FAIL reset_ready: in_ready=%b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    out_ready = 1;
    for (int i = 0; i < ND; i++) begin
      in_valid = 1; in_instr = dir_w[i];
      @(negedge clk);
      in_valid = 0;
      n_vec++;
      if (out_valid !== 1 || obs() !== dir_e[i]) begin
        n_bad++;
        $display("FAIL directed_%h: valid=%b got %h expected %h", dir_w[i], out_valid, obs(), dir_e[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ill_count();
    pulse_reset();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3); in_instr = 0;
      in_valid2 = 1; in_instr2 = 0;
      @(negedge clk);
    end
    in_valid = 0; in_valid2 = 0;
    @(negedge clk);
    n_vec++;
    if (ill_cnt !== 3) begin n_bad++; $display("FAIL ill_cnt: got %0d expected 3", ill_cnt); end
    n_vec++;
    if (ill_cnt2 !== 3) begin n_bad++; $display("FAIL ill_cnt_sat: got %0d expected 3", ill_cnt2); end
  endtask

  task automatic test_stall();
    logic [31:0] a = 32'hFFF10093, b = 32'h00532423;
    in_valid = 1; in_instr = a; out_ready = 0;
    @(negedge clk);
    in_instr = b;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid !== 1 || obs() !== model(a)) begin
        n_bad++; $display("FAIL stall_hold_%0d: valid=%b got %h expected %h", i, out_valid, obs(), model(a));
      end
`ifndef DECODE_SKID_BUF_EN
      n_vec++;
      if (in_ready !== 0) begin n_bad++; $display("FAIL stall_ready_%0d: in_ready=%b expected 0", i, in_ready); end
`endif
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1 || obs() !== model(b)) begin
      n_bad++; $display("FAIL stall_next: valid=%b got %h expected %h", out_valid, obs(), model(b));
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL stall_drain: out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      w = rand_instr();
      in_valid = 1; in_instr = w;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1 || obs() !== model(w)) begin
        n_bad++; $display("FAIL burst_%0d (%h): valid=%b got %h expected %h", i, w, out_valid, obs(), model(w));
      end
    end
    in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    pulse_reset();
    out_ready = 0; in_valid = 1; in_instr = 32'hFFF10093;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    flush = 1; in_valid = 1; in_instr = 0;
    @(negedge clk);
    flush = 0; in_valid = 0;
    n_vec++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL flush_valid: out_valid=%b expected 0", out_valid); end
    n_vec++;
    if (ill_cnt !== 0) begin n_bad++; $display("FAIL flush_cnt: ill_cnt=%0d expected 0", ill_cnt); end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL flush_drop: out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_random();
    dec_t e;
    int   exp_cnt = 0;
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid  = $urandom_range(0, 9) < 7;
      in_instr  = rand_instr();
      out_ready = $urandom_range(0, 9) < 7;
      #1;
      n_vec++;
      if (ill_cnt !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL rand_cnt cyc %0d: ill_cnt=%0d expected %0d", c, ill_cnt, exp_cnt);
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rand_spurious cyc %0d: got %h expected no output", c, obs());
        end else begin
          e = sb.pop_front();
          if (obs() !== e) begin n_bad++; $display("FAIL rand_out cyc %0d: got %h expected %h", c, obs(), e); end
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_instr);
        sb.push_back(e);
        if (e.ill) exp_cnt++;
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        e = sb.pop_front();
        n_vec++;
        if (obs() !== e) begin n_bad++; $display("FAIL drain_out: got %h expected %h", obs(), e); end
      end
      @(negedge clk);
    end
    n_vec++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_instr = 0;
      @(negedge clk);
    end
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (out_valid !== 0 || obs() !== '0 || ill_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset_mid: out_valid=%b fields=%h ill_cnt=%0d, expected 0/0/0", out_valid, obs(), ill_cnt);
    end
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1 || out_valid !== 0) begin
      n_bad++; $display("FAIL reset_mid_after: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ill_count();
    test_stall();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
